// File: rtl/dmem_sram_bridge_pkg.sv
// Shared definitions for the data-memory to SRAM bridge.
//   chan_state_e      : per-channel handshake state
//   SRAM_READ_LATENCY : cycles from the SRAM strobe to valid read data
//   idx_bits()        : index width for an N-entry selection, at least 1 bit
package dmem_sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_RD,
        REQ_WR,
        ISSUED_RD,
        ISSUED_WR,
        RESP_RD,
        RESP_WR
    } chan_state_e;

    localparam int SRAM_READ_LATENCY = 1;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal search pointer.
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   req         : request vector
//   grant       : one-hot grant, combinational from req and the pointer
//   grant_valid : some request was granted this cycle
// After a grant the pointer moves to the entry just past the winner, so
// every requester waits at most N-1 cycles.
module rr_arbiter
    import dmem_sram_bridge_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    localparam int PTR_W = idx_bits(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;
    logic [PTR_W:0]   sum;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-2 counts in range.
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            cand = sum[PTR_W-1:0];
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (grant_valid)
            ptr <= (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + PTR_W'(1);
    end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Bridges multi-channel valid/ready data-memory requests onto one
// single-port synchronous SRAM, one access per cycle, round-robin.
//   clk, reset             : clock, asynchronous active-high reset
//   mem_read_valid/address : per-channel read request (held while valid)
//   mem_read_ready/data    : read response, 4-phase handshake
//   mem_write_valid/address/data : per-channel write request
//   mem_write_ready        : write committed, 4-phase handshake
//   sram_en/we/addr/wdata  : registered SRAM port
//   sram_rdata             : SRAM read data, SRAM_READ_LATENCY after strobe
//
// state     | meaning
// IDLE      | no request; read wins if both valids are high
// REQ_RD    | read waiting for arbiter grant
// REQ_WR    | write waiting for arbiter grant
// ISSUED_RD | read on the SRAM port, waiting for data capture
// ISSUED_WR | write on the SRAM port
// RESP_RD   | read_ready high until read_valid drops
// RESP_WR   | write_ready high until write_valid drops
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [ADDR_BITS-1:0]    sram_addr,
    output logic [DATA_BITS-1:0]    sram_wdata,
    input  logic [DATA_BITS-1:0]    sram_rdata
);

    localparam int CH_W = idx_bits(NUM_CHANNELS);

    chan_state_e             state [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] arb_req;
    logic [NUM_CHANNELS-1:0] arb_grant;
    logic                    arb_grant_valid;
    logic [CH_W-1:0]         grant_ch;
    logic                    grant_is_wr;

    // Read tracking: stage 0 is the access on the SRAM port, the last stage
    // is the cycle in which sram_rdata holds that access's data.
    logic                    rd_pipe_vld [SRAM_READ_LATENCY+1];
    logic [CH_W-1:0]         rd_pipe_ch  [SRAM_READ_LATENCY+1];
    logic                    cap_vld;
    logic [CH_W-1:0]         cap_ch;

    assign cap_vld = rd_pipe_vld[SRAM_READ_LATENCY];
    assign cap_ch  = rd_pipe_ch[SRAM_READ_LATENCY];

    // A channel whose valid has already dropped is not offered to the
    // arbiter, so an abandoned request never reaches the SRAM.
    always_comb begin
        arb_req = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            arb_req[i] = (state[i] == REQ_RD && mem_read_valid[i]) ||
                         (state[i] == REQ_WR && mem_write_valid[i]);
    end

    always_comb begin
        grant_ch = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (arb_grant[i])
                grant_ch = CH_W'(i);
    end

    assign grant_is_wr = (state[grant_ch] == REQ_WR);

    rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (arb_req),
        .grant       (arb_grant),
        .grant_valid (arb_grant_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            for (int k = 0; k <= SRAM_READ_LATENCY; k++) begin
                rd_pipe_vld[k] <= 1'b0;
                rd_pipe_ch[k]  <= '0;
            end
        end else begin
            sram_en <= arb_grant_valid;
            if (arb_grant_valid) begin
                sram_we   <= grant_is_wr;
                sram_addr <= grant_is_wr ? mem_write_address[grant_ch]
                                         : mem_read_address[grant_ch];
                if (grant_is_wr)
                    sram_wdata <= mem_write_data[grant_ch];
            end
            rd_pipe_vld[0] <= arb_grant_valid && !grant_is_wr;
            rd_pipe_ch[0]  <= grant_ch;
            for (int k = 1; k <= SRAM_READ_LATENCY; k++) begin
                rd_pipe_vld[k] <= rd_pipe_vld[k-1];
                rd_pipe_ch[k]  <= rd_pipe_ch[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i]         <= IDLE;
                mem_read_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                case (state[i])
                    IDLE: begin
                        if (mem_read_valid[i])
                            state[i] <= REQ_RD;
                        else if (mem_write_valid[i])
                            state[i] <= REQ_WR;
                    end
                    REQ_RD: begin
                        if (!mem_read_valid[i])
                            state[i] <= IDLE;
                        else if (arb_grant[i])
                            state[i] <= ISSUED_RD;
                    end
                    REQ_WR: begin
                        if (!mem_write_valid[i])
                            state[i] <= IDLE;
                        else if (arb_grant[i])
                            state[i] <= ISSUED_WR;
                    end
                    // An early valid drop leaves the access to finish on the
                    // SRAM; the data is simply never captured or acknowledged.
                    ISSUED_RD: begin
                        if (!mem_read_valid[i])
                            state[i] <= IDLE;
                        else if (cap_vld && cap_ch == CH_W'(i)) begin
                            state[i]          <= RESP_RD;
                            mem_read_data[i]  <= sram_rdata;
                            mem_read_ready[i] <= 1'b1;
                        end
                    end
                    ISSUED_WR: begin
                        if (!mem_write_valid[i])
                            state[i] <= IDLE;
                        else begin
                            state[i]           <= RESP_WR;
                            mem_write_ready[i] <= 1'b1;
                        end
                    end
                    RESP_RD: begin
                        if (!mem_read_valid[i]) begin
                            state[i]          <= IDLE;
                            mem_read_ready[i] <= 1'b0;
                        end
                    end
                    RESP_WR: begin
                        if (!mem_write_valid[i]) begin
                            state[i]           <= IDLE;
                            mem_write_ready[i] <= 1'b0;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
module tb_dmem_sram_bridge;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] rv, wv, rr, wr;
    logic [AW-1:0] raddr [NC];
    logic [AW-1:0] waddr [NC];
    logic [DW-1:0] wdat  [NC];
    logic [DW-1:0] rdat  [NC];
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    always #5 clk = ~clk;

    dmem_sram_bridge #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(NC)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (rv),
        .mem_read_address  (raddr),
        .mem_read_ready    (rr),
        .mem_read_data     (rdat),
        .mem_write_valid   (wv),
        .mem_write_address (waddr),
        .mem_write_data    (wdat),
        .mem_write_ready   (wr),
        .sram_en           (sram_en),
        .sram_we           (sram_we),
        .sram_addr         (sram_addr),
        .sram_wdata        (sram_wdata),
        .sram_rdata        (sram_rdata)
    );

    // Behavioural single-port SRAM, one cycle read latency.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } acc_t;
    acc_t acc_log[$];
    always @(negedge clk) if (sram_en) acc_log.push_back('{sram_we, sram_addr, sram_wdata, pcyc});

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        rv = '0;
        wv = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        @(negedge clk);
        wv[ch] = 1'b1; waddr[ch] = a; wdat[ch] = d;
        lat = -1;
        for (int it = 1; it <= 20; it++) begin
            @(negedge clk);
            if (wr[ch]) begin lat = it - 1; break; end
        end
        wv[ch] = 1'b0;
        for (int k = 0; k < 20 && wr[ch]; k++) @(negedge clk);
    endtask

    task automatic do_read(input int ch, input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d);
        @(negedge clk);
        rv[ch] = 1'b1; raddr[ch] = a;
        lat = -1; d = '0;
        for (int it = 1; it <= 20; it++) begin
            @(negedge clk);
            if (rr[ch]) begin lat = it - 1; d = rdat[ch]; break; end
        end
        rv[ch] = 1'b0;
        for (int k = 0; k < 20 && rr[ch]; k++) @(negedge clk);
    endtask

    // Multi-channel 4-phase read master. Addresses come from raddr[].
    int            m_lat [NC];
    int            m_maxlat [NC];
    int            m_cnt [NC];
    int            m_rr_seen [NC];
    logic [DW-1:0] m_data [NC];
    logic          m_done;

    task automatic run_reads(input logic [NC-1:0] mask, input int n_each,
                             input logic [NC-1:0] abandon, input int max_iter);
        int started [NC];
        int raise_it [NC];
        logic all_idle;
        for (int c = 0; c < NC; c++) begin
            started[c] = 0; raise_it[c] = 0; m_lat[c] = -1; m_maxlat[c] = 0;
            m_cnt[c] = 0; m_rr_seen[c] = 0; m_data[c] = '0;
        end
        m_done = 1'b0;
        for (int it = 0; it < max_iter; it++) begin
            @(negedge clk);
            for (int c = 0; c < NC; c++) begin
                if (mask[c]) begin
                    if (rr[c]) m_rr_seen[c]++;
                    if (abandon[c] && it == 1) begin
                        rv[c] = 1'b0;
                        started[c] = n_each;
                    end else if (rv[c] && rr[c]) begin
                        m_lat[c]  = it - raise_it[c] - 1;
                        m_data[c] = rdat[c];
                        if (m_lat[c] > m_maxlat[c]) m_maxlat[c] = m_lat[c];
                        m_cnt[c]++;
                        rv[c] = 1'b0;
                    end else if (!rv[c] && !rr[c] && started[c] < n_each) begin
                        rv[c] = 1'b1;
                        raise_it[c] = it;
                        started[c]++;
                    end
                end
            end
            all_idle = 1'b1;
            for (int c = 0; c < NC; c++)
                if (mask[c] && (started[c] < n_each || rv[c] || rr[c])) all_idle = 1'b0;
            if (all_idle) begin m_done = 1'b1; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mark, viol;
        logic [DW-1:0] d;

        reset = 1'b1;
        rv = '0; wv = '0;
        for (int c = 0; c < NC; c++) begin raddr[c] = '0; waddr[c] = '0; wdat[c] = '0; end
        repeat (3) @(negedge clk);
        check_eq("rst_sram_en", sram_en, 0);
        check_eq("rst_sram_addr", sram_addr, 0);
        check_eq("rst_rd_ready", rr, 0);
        check_eq("rst_wr_ready", wr, 0);
        check_eq("rst_rd_data0", rdat[0], 0);
        reset = 1'b0;

        // Single write then read on channel 0.
        mark = acc_log.size();
        do_write(0, 8'h10, 8'hA5, lat);
        check_eq("t1_wr_lat", lat, 2);
        check_eq("t1_wr_count", acc_log.size() - mark, 1);
        check_eq("t1_wr_we", acc_log[mark].we, 1);
        check_eq("t1_wr_addr", acc_log[mark].addr, 8'h10);
        check_eq("t1_wr_data", acc_log[mark].data, 8'hA5);
        do_read(0, 8'h10, lat, d);
        check_eq("t1_rd_lat", lat, 3);
        check_eq("t1_rd_data", d, 8'hA5);

        // Four simultaneous reads with pointer at 0.
        do_write(0, 8'h00, 8'h11, lat);
        do_write(0, 8'h01, 8'h22, lat);
        do_write(0, 8'h02, 8'h33, lat);
        do_write(0, 8'h03, 8'h44, lat);
        apply_reset();
        for (int c = 0; c < NC; c++) raddr[c] = AW'(c);
        mark = acc_log.size();
        run_reads(4'hF, 1, 4'h0, 40);
        check_eq("t2_done", m_done, 1);
        for (int c = 0; c < NC; c++) begin
            check_eq($sformatf("t2_lat%0d", c), m_lat[c], 3 + c);
            check_eq($sformatf("t2_data%0d", c), m_data[c], 8'h11 * (c + 1));
            check_eq($sformatf("t2_order%0d", c), acc_log[mark + c].addr, c);
        end
        for (int c = 1; c < NC; c++)
            check_eq($sformatf("t2_gap%0d", c), acc_log[mark + c].cyc - acc_log[mark + c - 1].cyc, 1);

        // Fairness between channels 0 and 2.
        raddr[0] = 8'h40; raddr[2] = 8'h42;
        mark = acc_log.size();
        run_reads(4'b0101, 4, 4'h0, 80);
        check_eq("t3_done", m_done, 1);
        check_eq("t3_cnt0", m_cnt[0], 4);
        check_eq("t3_cnt2", m_cnt[2], 4);
        viol = 0;
        for (int i = mark + 1; i < acc_log.size(); i++)
            if (acc_log[i].addr == acc_log[i-1].addr) viol++;
        check_eq("t3_alternate", viol, 0);
        check_eq("t3_accesses", acc_log.size() - mark, 8);
        check_eq("t3_wait0", m_maxlat[0] <= 6, 1);
        check_eq("t3_wait2", m_maxlat[2] <= 6, 1);

        // Read/write priority on channel 1.
        do_write(1, 8'h20, 8'h07, lat);
        @(negedge clk);
        rv[1] = 1'b1; raddr[1] = 8'h20;
        wv[1] = 1'b1; waddr[1] = 8'h20; wdat[1] = 8'h99;
        mark = acc_log.size();
        begin
            int rlat, early_w, wseen;
            logic [DW-1:0] rd;
            rlat = -1; early_w = 0; wseen = 0; rd = '0;
            for (int it = 1; it <= 20; it++) begin
                @(negedge clk);
                if (wr[1]) early_w = 1;
                if (rr[1]) begin rlat = it - 1; rd = rdat[1]; break; end
            end
            rv[1] = 1'b0;
            for (int it = 1; it <= 20; it++) begin
                @(negedge clk);
                if (wr[1]) begin wseen = 1; break; end
            end
            wv[1] = 1'b0;
            for (int k = 0; k < 20 && wr[1]; k++) @(negedge clk);
            check_eq("t4_rd_lat", rlat, 3);
            check_eq("t4_rd_data", rd, 8'h07);
            check_eq("t4_wr_not_first", early_w, 0);
            check_eq("t4_wr_done", wseen, 1);
        end
        check_eq("t4_first_is_rd", acc_log[mark].we, 0);
        check_eq("t4_second_is_wr", acc_log[mark + 1].we, 1);
        check_eq("t4_second_data", acc_log[mark + 1].data, 8'h99);
        do_read(1, 8'h20, lat, d);
        check_eq("t4_reread", d, 8'h99);

        // Abandon on channel 3 behind three contenders, then pointer check.
        apply_reset();
        raddr[0] = 8'h30; raddr[1] = 8'h31; raddr[2] = 8'h32; raddr[3] = 8'h33;
        mark = acc_log.size();
        run_reads(4'hF, 1, 4'b1000, 40);
        check_eq("t5_done", m_done, 1);
        viol = 0;
        for (int i = mark; i < acc_log.size(); i++)
            if (acc_log[i].addr == 8'h33) viol++;
        check_eq("t5_no_ch3_access", viol, 0);
        check_eq("t5_ch3_ready", m_rr_seen[3], 0);
        check_eq("t5_ch2_served", m_cnt[2], 1);
        raddr[1] = 8'h51; raddr[3] = 8'h53;
        mark = acc_log.size();
        run_reads(4'b1010, 1, 4'h0, 40);
        check_eq("t5_ptr_first", acc_log[mark].addr, 8'h53);
        check_eq("t5_ptr_second", acc_log[mark + 1].addr, 8'h51);

        // Reset one cycle after a grant, with channel 1 holding write_ready.
        @(negedge clk);
        wv[1] = 1'b1; waddr[1] = 8'h60; wdat[1] = 8'h5A;
        for (int k = 0; k < 20 && !wr[1]; k++) @(negedge clk);
        check_eq("t6_wr_ready_pre", wr[1], 1);
        rv[0] = 1'b1; raddr[0] = 8'h10;
        repeat (2) @(negedge clk);
        check_eq("t6_sram_en_pre", sram_en, 1);
        reset = 1'b1;
        #1;
        check_eq("t6_sram_en_async", sram_en, 0);
        check_eq("t6_rd_ready_async", rr, 0);
        check_eq("t6_wr_ready_async", wr, 0);
        check_eq("t6_rd_data1_async", rdat[1], 0);
        rv = '0; wv = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        raddr[0] = 8'h10; raddr[3] = 8'h13;
        mark = acc_log.size();
        run_reads(4'b1001, 1, 4'h0, 40);
        check_eq("t6_ptr_first", acc_log[mark].addr, 8'h10);
        check_eq("t6_clean_data", m_data[0], 8'hA5);
        check_eq("t6_clean_lat", m_lat[0], 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sram_bridge.md
Name: dmem_sram_bridge

Overview:
- Sits directly downstream of the GPU data-memory ports.
- Terminates the multi-channel valid/ready read/write protocol from the data memory controller.
- Serialises all channel requests onto one single-port synchronous SRAM, arbitrated round-robin, at most one SRAM access per cycle.
- Returns read data and write acknowledgements per channel with a 4-phase handshake.

Parameters:
- ADDR_BITS, 8, data memory address width; SRAM depth is 2**ADDR_BITS.
- DATA_BITS, 8, data word width.
- NUM_CHANNELS, 4, number of independent request channels.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request.
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS  read address, held while valid.
- mem_read_ready  out  NUM_CHANNELS  read data available.
- mem_read_data  out  DATA_BITS x NUM_CHANNELS  read data, stable while ready.
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS  write address, held while valid.
- mem_write_data  in  DATA_BITS x NUM_CHANNELS  write data, held while valid.
- mem_write_ready  out  NUM_CHANNELS  write committed.
- sram_en  out  1  SRAM access strobe (registered).
- sram_we  out  1  1 = write, 0 = read (registered).
- sram_addr  out  ADDR_BITS  SRAM address (registered).
- sram_wdata  out  DATA_BITS  SRAM write data (registered).
- sram_rdata  in  DATA_BITS  SRAM read data, valid exactly one cycle after sram_en with sram_we=0.

Behaviour:
- Reset (async assert, sync release):
  - all mem_*_ready = 0, mem_read_data = 0.
  - sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
  - all channel FSMs to IDLE; round-robin pointer = 0.
  - Reset mid-operation discards every in-flight access, including a write already on the SRAM port (the SRAM may still commit it).
- Per-channel FSM states:
  - IDLE: read_valid high -> REQ_RD; else write_valid high -> REQ_WR. Read has priority when both are high; the write is served after the read handshake closes.
  - REQ_RD / REQ_WR: channel requests the arbiter. When granted in cycle T, the SRAM port is loaded at the end of T -> ISSUED_RD / ISSUED_WR.
  - ISSUED_RD: sram_rdata sampled at end of T+2 into mem_read_data -> RESP_RD; read_ready = 1 from cycle T+3.
  - ISSUED_WR: -> RESP_WR; write_ready = 1 from cycle T+2.
  - RESP_*: ready is held high until the matching valid is sampled low, then ready drops next cycle -> IDLE.
  - A new request is not accepted in the same cycle ready drops.
- Uncontended latency: read_ready rises 3 cycles after read_valid is first sampled high; write_ready rises 2 cycles after.
- Arbitration:
  - One grant per cycle among channels in REQ_*.
  - Search starts at the pointer; after a grant the pointer = granted index + 1, wrapping at NUM_CHANNELS.
  - No grant means sram_en = 0 next cycle.
  - Starvation bound: NUM_CHANNELS-1 cycles of waiting.
- Ordering: SRAM accesses execute in grant order. A write granted in cycle T is visible to a read granted in T+1 or later.
- Protocol violation (valid dropped before ready):
  - In REQ_*: request abandoned -> IDLE, no SRAM access.
  - In ISSUED_*: access completes on the SRAM, ready is never asserted -> IDLE.
- Widths: no arithmetic on data. Addresses pass through unchanged. The pointer is $clog2(NUM_CHANNELS) bits, with wrap handled explicitly for non-power-of-2 channel counts.
- mem_read_data[i] changes only on the RESP_RD entry capture.

Decomposition:
- Shared gpu package holds the channel state enum (IDLE, REQ_RD, REQ_WR, ISSUED_RD, ISSUED_WR, RESP_RD, RESP_WR) and a SRAM_READ_LATENCY = 1 constant.
- One sub-module: rr_arbiter (parameter N; inputs req[N]; outputs grant one-hot and grant_valid; holds the pointer internally). It is reusable by the program memory path.

Test Plan:
- Single write then read, channel 0: write addr 0x10 data 0xA5. Expect write_ready[0] at +2 cycles and exactly one SRAM write (0x10, 0xA5). Then read 0x10: read_ready[0] at +3 cycles, read_data[0] = 0xA5.
- Four channels read simultaneously from addresses 0x00..0x03, preloaded 0x11, 0x22, 0x33, 0x44, pointer 0:
  - grants in order 0, 1, 2, 3 on consecutive cycles.
  - read_ready rises at +3, +4, +5, +6.
  - each channel returns its own value.
- Fairness: channels 0 and 2 hold back-to-back requests for 20 cycles. Expect strictly alternating grants; neither channel waits more than 3 cycles for a grant.
- Read/write priority on channel 1: both valid, read 0x20 (holding 0x07), write 0x20 <- 0x99. Expect read completes first returning 0x07, then the write. A later read returns 0x99.
- Abandon: channel 3 drops read_valid while in REQ_RD behind 3 contenders. Expect no SRAM access for channel 3 and read_ready[3] stays 0.
- Reset mid-operation: assert reset one cycle after a grant. Expect all ready and sram_en low immediately (async), pointer 0, and clean operation after release.
